// File: rtl/tetris_pkg.sv
// Shared types and default geometry for the line-clear engine.
// Imported by the engine top and the spawn footprint generator.
package tetris_pkg;

    localparam int DEF_COLS = 4;
    localparam int DEF_ROWS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FILL,
        SPAWN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        PIECE_SINGLE = 2'b00,
        PIECE_DOMINO = 2'b01,
        PIECE_SQUARE = 2'b10,
        PIECE_L      = 2'b11
    } piece_e;

endpackage

// File: rtl/piece_mask_gen.sv
// Combinational spawn footprint for a piece, anchored at (row 0, SPAWN_COL).
// Bit index of cell (r, c) is r*COLS + c.
module piece_mask_gen
    import tetris_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int SPAWN_COL = 1
) (
    input  logic [1:0]           curr_piece,
    output logic [COLS*ROWS-1:0] mask
);

    localparam int C0 = SPAWN_COL;
    localparam int C1 = SPAWN_COL + 1;
    localparam int R1 = COLS;

    piece_e piece;
    assign piece = piece_e'(curr_piece);

    always_comb begin
        mask = '0;
        unique case (1'b1)
            (piece == PIECE_SINGLE): begin
                mask[C0] = 1'b1;
            end
            (piece == PIECE_DOMINO): begin
                mask[C0] = 1'b1;
                mask[C1] = 1'b1;
            end
            (piece == PIECE_SQUARE): begin
                mask[C0]      = 1'b1;
                mask[C1]      = 1'b1;
                mask[R1 + C0] = 1'b1;
                mask[R1 + C1] = 1'b1;
            end
            (piece == PIECE_L): begin
                mask[C0]      = 1'b1;
                mask[R1 + C0] = 1'b1;
                mask[R1 + C1] = 1'b1;
            end
            default: begin
                mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/line_clear_engine.sv
// Removes full rows from a board snapshot, compacts it downward and
// spawns the current piece at the top, flagging overlap as game over.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int SPAWN_COL = 1
) (
    input  logic                         clka,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [COLS*ROWS-1:0]         board_in,
    input  logic [1:0]                   curr_piece,
    output logic                         busy,
    output logic                         done,
    output logic [COLS*ROWS-1:0]         board_out,
    output logic [$clog2(ROWS+1)-1:0]    lines_cleared,
    output logic                         error
);

    localparam int N  = COLS * ROWS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + 1);

    if (COLS < SPAWN_COL + 2 || ROWS < 2) begin : g_bad_params
        $error("line_clear_engine: need COLS >= SPAWN_COL+2 and ROWS >= 2");
    end

    state_e          state;
    state_e          state_nxt;
    logic [N-1:0]    board_q;
    logic [N-1:0]    mask;
    logic [1:0]      piece_q;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   wr;
    logic [CW-1:0]   count;
    logic [COLS-1:0] rd_row;
    logic            rd_full;

    piece_mask_gen #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .SPAWN_COL (SPAWN_COL)
    ) u_mask (
        .curr_piece (piece_q),
        .mask       (mask)
    );

    assign rd_row  = board_q[rd*COLS +: COLS];
    assign rd_full = &rd_row;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (rd == '0) state_nxt = FILL;
            FILL:    state_nxt = SPAWN;
            SPAWN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            board_q       <= '0;
            piece_q       <= '0;
            rd            <= '0;
            wr            <= '0;
            count         <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            error         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        board_q <= board_in;
                        piece_q <= curr_piece;
                        rd      <= RW'(ROWS - 1);
                        wr      <= RW'(ROWS - 1);
                        count   <= '0;
                    end
                end
                SCAN: begin
                    // wr never passes rd, so unread rows are never overwritten
                    if (rd_full) begin
                        count <= count + CW'(1);
                    end else begin
                        board_q[wr*COLS +: COLS] <= rd_row;
                        wr <= wr - RW'(1);
                    end
                    rd <= rd - RW'(1);
                end
                FILL: begin
                    // with no clears wr has wrapped, so the count gates it
                    for (int r = 0; r < ROWS; r++) begin
                        if (count != '0 && RW'(r) <= wr) begin
                            board_q[r*COLS +: COLS] <= '0;
                        end
                    end
                end
                SPAWN: begin
                    board_out     <= board_q | mask;
                    error         <= |(board_q & mask);
                    lines_cleared <= count;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed vector table, random boards
// against a row-list reference model, and start/reset control sequences.
module tb_line_clear_engine;

    localparam int COLS      = 4;
    localparam int ROWS      = 8;
    localparam int SPAWN_COL = 1;
    localparam int N         = COLS * ROWS;

    logic         clka = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] board_in = '0;
    logic [1:0]   curr_piece = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] board_out;
    logic [3:0]   lines_cleared;
    logic         error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    line_clear_engine #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .SPAWN_COL (SPAWN_COL)
    ) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .start         (start),
        .board_in      (board_in),
        .curr_piece    (curr_piece),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .error         (error)
    );

    typedef struct {
        logic [N-1:0] b;
        logic [1:0]   p;
        logic [N-1:0] bo;
        logic [3:0]   lc;
        logic         err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: keep non-full rows bottom-up, restack them at the
    // bottom, then overlay the spawn cells listed per piece.
    task automatic model(input logic [N-1:0] b, input logic [1:0] p,
                         output logic [N-1:0] bo, output logic [3:0] lc,
                         output logic err);
        logic [COLS-1:0] kept[$];
        logic [COLS-1:0] row;
        logic [N-1:0]    m;
        int              cells[$];
        lc = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (row == '1) lc++;
            else kept.push_back(row);
        end
        bo = '0;
        for (int i = 0; i < kept.size(); i++)
            bo[(ROWS-1-i)*COLS +: COLS] = kept[i];
        case (p)
            2'b00: cells = '{0, 0};
            2'b01: cells = '{0, 0, 0, 1};
            2'b10: cells = '{0, 0, 0, 1, 1, 0, 1, 1};
            default: cells = '{0, 0, 1, 0, 1, 1};
        endcase
        m = '0;
        for (int i = 0; i < cells.size(); i += 2)
            m[cells[i]*COLS + SPAWN_COL + cells[i+1]] = 1'b1;
        err = |(m & bo);
        bo  = bo | m;
    endtask

    task automatic run_pass(input logic [N-1:0] b, input logic [1:0] p,
                            output int lat);
        int k;
        @(negedge clka);
        start = 1'b1;
        board_in = b;
        curr_piece = p;
        @(negedge clka);
        start = 1'b0;
        k = 0;
        chk("busy_after_start", busy, 1);
        while (!done && k < 40) begin
            @(negedge clka);
            k++;
        end
        chk("done_seen", done, 1);
        lat = k + 1;
    endtask

    task automatic check_pass(input string tag, input logic [N-1:0] b,
                              input logic [1:0] p, input logic [N-1:0] bo,
                              input logic [3:0] lc, input logic err);
        int lat;
        run_pass(b, p, lat);
        chk({tag, "_board"}, board_out, bo);
        chk({tag, "_lines"}, lines_cleared, lc);
        chk({tag, "_error"}, error, err);
        chk({tag, "_latency"}, lat, ROWS + 3);
        @(negedge clka);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [N-1:0] rb;
        logic [N-1:0] ebo;
        logic [3:0]   elc;
        logic         eerr;
        logic [1:0]   rp;
        int           ndone;
        int           k;

        vecs[0] = '{32'h0000_0000, 2'b10, 32'h0000_0066, 4'd0, 1'b0};
        vecs[1] = '{32'hF000_0000, 2'b00, 32'h0000_0002, 4'd1, 1'b0};
        vecs[2] = '{32'hFF31_0000, 2'b01, 32'h3100_0006, 4'd2, 1'b0};
        vecs[3] = '{32'hF2F0_0000, 2'b11, 32'h2000_0062, 4'd2, 1'b0};
        vecs[4] = '{32'h0000_0002, 2'b00, 32'h0000_0002, 4'd0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 2'b11, 32'h0000_0062, 4'd8, 1'b0};

        repeat (3) @(negedge clka);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_board", board_out, 0);
        chk("rst_lines", lines_cleared, 0);
        rst_n = 1'b1;
        @(negedge clka);

        foreach (vecs[i])
            check_pass($sformatf("vec%0d", i), vecs[i].b, vecs[i].p,
                       vecs[i].bo, vecs[i].lc, vecs[i].err);

        for (int t = 0; t < 40; t++) begin
            rb = '0;
            for (int r = 0; r < ROWS; r++)
                rb[r*COLS +: COLS] = ($urandom_range(2) == 0) ?
                                     4'hF : 4'($urandom);
            rp = 2'($urandom_range(3));
            model(rb, rp, ebo, elc, eerr);
            check_pass($sformatf("rnd%0d", t), rb, rp, ebo, elc, eerr);
        end

        // second start mid-pass must be ignored
        @(negedge clka);
        start = 1'b1;
        board_in = 32'hFF31_0000;
        curr_piece = 2'b01;
        @(negedge clka);
        start = 1'b0;
        @(negedge clka);
        start = 1'b1;
        board_in = 32'hF000_0000;
        curr_piece = 2'b00;
        @(negedge clka);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clka);
            k++;
        end
        chk("ctl_done_seen", done, 1);
        chk("ctl_board", board_out, 32'h3100_0006);
        chk("ctl_lines", lines_cleared, 2);
        // start coinciding with done must not launch a pass
        start = 1'b1;
        board_in = 32'h0;
        @(negedge clka);
        start = 1'b0;
        chk("ctl_start_at_done", busy, 0);
        ndone = 0;
        repeat (15) begin
            @(negedge clka);
            if (done) ndone++;
        end
        chk("ctl_single_done", ndone, 0);

        // reset part way through a pass
        @(negedge clka);
        start = 1'b1;
        board_in = 32'h0;
        curr_piece = 2'b10;
        @(negedge clka);
        start = 1'b0;
        repeat (3) @(negedge clka);
        chk("hold_busy", busy, 1);
        chk("hold_board", board_out, 32'h3100_0006);
        chk("hold_lines", lines_cleared, 2);
        rst_n = 1'b0;
        @(negedge clka);
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_board", board_out, 0);
        chk("mid_rst_lines", lines_cleared, 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clka);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);

        check_pass("after_rst", 32'hF2F0_0000, 2'b11, 32'h2000_0062,
                   4'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
